param_universal_shift_reg: RTL
==============================

# param_universal_shift_reg

Parametrised universal shift register: the next generation of the team's 4-bit shift register. It generalises the width and adds rotate, arithmetic-shift and multi-bit-per-cycle shift modes. It also tracks how many bit positions have been shifted out since the last load, so a serialiser can detect when a loaded word is fully consumed. It sits between a parallel word source and a serial link or bit-level datapath.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- AW, $clog2(WIDTH), width of AMT (derived; do not override).
- CW, $clog2(WIDTH)+1, width of CNT (derived; do not override).

- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset; highest priority.
- ENB  input  1  enable; 0 holds all state.
- DIR  input  1  0 = shift/rotate left (toward MSB), 1 = right (toward LSB).
- S_IN  input  1  serial fill bit for logical shift.
- MODO  input  2  mode: 00 logical shift, 01 rotate, 10 parallel load, 11 arithmetic shift.
- AMT  input  AW  shift distance minus one: distance k = AMT+1, range 1..WIDTH.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- S_OUT  output  1  registered copy of the last bit shifted or rotated out.
- CNT  output  CW  bit positions moved since the last load/reset; saturates at WIDTH.
- DONE  output  1  registered; 1 when CNT == WIDTH.

## Operation
- Reset: Q=0, S_OUT=0, CNT=0, DONE=0. RST overrides ENB and MODO.
- ENB=0 and RST=0: Q, S_OUT, CNT and DONE all hold.
- MODO=10, load:
  - Q=D, CNT=0, DONE=0, S_OUT=0.
  - DIR, AMT and S_IN are ignored.
- MODO=00, logical shift by k:
  - Left: Q = {Q[WIDTH-1-k:0], k copies of S_IN}.
  - Right: Q = {k copies of S_IN, Q[WIDTH-1:k]}.
  - When k=WIDTH, Q becomes all S_IN.
- MODO=01, rotate by k: bits leaving one end re-enter the other. k=WIDTH leaves Q unchanged.
- MODO=11, arithmetic shift by k:
  - Right: fill with old Q[WIDTH-1] (sign extension).
  - Left: fill with 0.
  - S_IN is ignored.
- S_OUT after a shift or rotate:
  - Left: old Q[WIDTH-k].
  - Right: old Q[k-1].
- CNT after a shift or rotate: CNT = min(CNT+k, WIDTH), computed without overflow in CW bits.
- DONE is asserted in the same cycle CNT reaches WIDTH. It stays asserted through further shifts and clears only on load or reset.

## Timing
- All outputs are registered. A command sampled at edge n is visible on Q, S_OUT, CNT and DONE after edge n. Latency is 1 cycle.
- One operation per enabled cycle; there are no multi-cycle operations and no stalls.
- No combinational path from inputs to outputs.
- Priority per edge: RST > ENB=0 (hold) > MODO.
- Reset mid-sequence discards all progress: CNT=0 on the next cycle regardless of the pending MODO.
- A load while DONE=1 clears DONE on the same edge.
- A shift with CNT already at WIDTH keeps CNT=WIDTH. Q and S_OUT still update normally.

## Test plan
- WIDTH=4, load D=0001, then 5 cycles of MODO=00, DIR=0, AMT=0, S_IN=0:
  - Q goes 0010, 0100, 1000, 0000, 0000.
  - S_OUT=1 only after the 4th shift.
  - CNT goes 1, 2, 3, 4, 4; DONE=1 from the 4th shift.
- WIDTH=8, load 0x90, then MODO=11, DIR=1, AMT=2 (k=3):
  - Q=0xF2, S_OUT=0, CNT=3, DONE=0.
- WIDTH=8, load 0xA5, then MODO=01, DIR=1, AMT=3:
  - After the 1st rotate: Q=0x5A, S_OUT=0, CNT=4.
  - After the 2nd rotate: Q=0xA5, CNT=8, DONE=1.
  - Then a load of 0x3C: Q=0x3C, CNT=0, DONE=0.
- WIDTH=8, MODO=00, DIR=1, AMT=7 (k=8), S_IN=1, from Q=0x81:
  - Q=0xFF, S_OUT=1, CNT=8, DONE=1.
- WIDTH=4, load D=0110, then ENB=0 for 3 cycles with MODO=00 toggling:
  - Q=0110, CNT=0 and S_OUT=0 stay unchanged.
  - Then assert RST with ENB=0: all outputs read 0 after the edge.
- Any width: assert RST in the same cycle as MODO=10 with D=all ones:
  - Q=0 and CNT=0 after the edge (reset wins).

Source files
------------

// File: rtl/param_universal_shift_reg_if.sv
// Bundle of command and status signals for param_universal_shift_reg.
// The master drives commands and data; the slave (the register) returns state.
interface param_universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             ENB;
  logic             DIR;
  logic             S_IN;
  logic [1:0]       MODO;
  logic [AW-1:0]    AMT;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             S_OUT;
  logic [CW-1:0]    CNT;
  logic             DONE;

  modport master (
    output ENB, DIR, S_IN, MODO, AMT, D,
    input  Q, S_OUT, CNT, DONE
  );

  modport slave (
    input  ENB, DIR, S_IN, MODO, AMT, D,
    output Q, S_OUT, CNT, DONE
  );
endinterface

// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register: logical/arithmetic shift, rotate and
// parallel load by 1..WIDTH positions per cycle, with a consumed-bit counter.
module param_universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  param_universal_shift_reg_if.slave bus
);
  localparam int AW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
  localparam logic [AW-1:0]    TOP_IDX = AW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ASHIFT = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_r;
  logic             s_out_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;

  logic [CW-1:0]    k;
  logic [CW-1:0]    rk;
  logic             fill;
  logic [WIDTH-1:0] fill_l;
  logic [WIDTH-1:0] fill_r;
  logic [WIDTH-1:0] q_next;
  logic [AW-1:0]    out_idx;
  logic             out_bit;
  logic [CW:0]      cnt_sum;
  logic [CW-1:0]    cnt_next;

  assign mode = mode_e'(bus.MODO);

  // Shift distance k = AMT+1; shifting by k == WIDTH naturally yields zero,
  // which makes full-width shifts come out as pure fill and rotates as identity.
  always_comb begin
    k       = {1'b0, bus.AMT} + CW'(1);
    rk      = WIDTH_C - k;
    fill    = bus.S_IN;
    if (mode == MODE_ASHIFT) begin
      fill = bus.DIR ? q_r[WIDTH-1] : 1'b0;
    end
    fill_l  = fill ? ~(ONES << k) : '0;
    fill_r  = fill ? ~(ONES >> k) : '0;
    q_next  = q_r;
    if (mode == MODE_ROTATE) begin
      q_next = bus.DIR ? ((q_r >> k) | (q_r << rk)) : ((q_r << k) | (q_r >> rk));
    end else begin
      q_next = bus.DIR ? ((q_r >> k) | fill_r) : ((q_r << k) | fill_l);
    end
    out_idx = bus.DIR ? bus.AMT : (TOP_IDX - bus.AMT);
    out_bit = q_r[out_idx];
    cnt_sum = {1'b0, cnt_r} + {1'b0, k};
    cnt_next = (cnt_sum >= {1'b0, WIDTH_C}) ? WIDTH_C : cnt_sum[CW-1:0];
  end

  // Reset beats hold, hold beats any command.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r     <= '0;
      s_out_r <= 1'b0;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else if (bus.ENB) begin
      if (mode == MODE_LOAD) begin
        q_r     <= bus.D;
        s_out_r <= 1'b0;
        cnt_r   <= '0;
        done_r  <= 1'b0;
      end else begin
        q_r     <= q_next;
        s_out_r <= out_bit;
        cnt_r   <= cnt_next;
        done_r  <= (cnt_next == WIDTH_C);
      end
    end
  end

  assign bus.Q     = q_r;
  assign bus.S_OUT = s_out_r;
  assign bus.CNT   = cnt_r;
  assign bus.DONE  = done_r;
endmodule
